// File: rtl/movwide_seq_pkg.sv
// Shared widths, opcode bases, state encoding and the MOVZ/MOVK datapath model
// used by the wide-immediate load sequencer.
package movwide_seq_pkg;

  localparam int unsigned WORDSIZE   = 64;
  localparam int unsigned OPCODESIZE = 11;
  localparam int unsigned SHAMTSIZE  = 6;
  localparam int unsigned HWSIZE     = 16;
  localparam int unsigned REGSIZE    = 5;

  localparam logic [OPCODESIZE-1:0] OP_MOVZ = 11'b11010010100;
  localparam logic [OPCODESIZE-1:0] OP_MOVK = 11'b11110010100;
  localparam logic [REGSIZE-1:0]    XZR     = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ZERO  = 2'd1,
    S_KEEP  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  typedef struct packed {
    logic [REGSIZE-1:0]  rd;
    logic [WORDSIZE-1:0] imm;
  } req_t;

  // MOVZ/MOVK datapath: opcode[1:0] selects the halfword, opcode[8] keeps readreg
  function automatic logic [WORDSIZE-1:0] mov_op(input logic [OPCODESIZE-1:0] opcode,
                                                 input logic [HWSIZE-1:0]     imm16,
                                                 input logic [WORDSIZE-1:0]   readreg);
    logic [SHAMTSIZE-1:0] shamt;
    logic [WORDSIZE-1:0]  ext;
    logic [WORDSIZE-1:0]  keep;
    shamt = {opcode[1:0], 4'b0000};
    ext   = WORDSIZE'(imm16) << shamt;
    keep  = ~(WORDSIZE'(16'hFFFF) << shamt);
    return opcode[8] ? ((readreg & keep) | ext) : ext;
  endfunction

  function automatic logic [3:0] nz_mask(input logic [WORDSIZE-1:0] imm);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i] = |imm[HWSIZE*i +: HWSIZE];
    return m;
  endfunction

endpackage

// File: rtl/movwide_seq_hw_pick.sv
// Lowest-set-bit finder over the pending-halfword mask.
module hw_pick
  import movwide_seq_pkg::*;
(
  input  logic [3:0] mask,
  output logic [1:0] idx,
  output logic       any
);

  always_comb begin
    idx = 2'd0;
    any = |mask;
    if      (mask[0]) idx = 2'd0;
    else if (mask[1]) idx = 2'd1;
    else if (mask[2]) idx = 2'd2;
    else if (mask[3]) idx = 2'd3;
  end

endmodule

// File: rtl/movwide_seq.sv
// Wide-immediate load sequencer: one MOVZ plus up to three MOVKs build a
// 64-bit constant, followed by a single register-file write.
module movwide_seq
  import movwide_seq_pkg::*;
#(
  parameter int unsigned SKIP_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [REGSIZE-1:0]  req_rd,
  input  logic [WORDSIZE-1:0] req_imm,
  output logic                wr_en,
  input  logic                wr_ready,
  output logic [REGSIZE-1:0]  wr_reg,
  output logic [WORDSIZE-1:0] wr_data,
  output logic                done,
  output logic [2:0]          steps
);

  state_t                state;
  req_t                  req_q;
  logic [WORDSIZE-1:0]   acc;
  logic [3:0]            mask;
  logic [2:0]            ops;

  logic [1:0]            hw_c;
  logic                  any_c;
  logic [3:0]            onehot_c;
  logic                  more_c;
  logic [OPCODESIZE-1:0] opcode_c;
  logic [HWSIZE-1:0]     imm16_c;
  logic [WORDSIZE-1:0]   movres_c;

  hw_pick u_pick (
    .mask (mask),
    .idx  (hw_c),
    .any  (any_c)
  );

  assign req_ready = (state == S_IDLE);

  // Datapath operand selection for the current MOVZ/MOVK step
  always_comb begin
    onehot_c = 4'b0001 << hw_c;
    more_c   = any_c && (|(mask & ~onehot_c));
    opcode_c = ((state == S_KEEP) ? OP_MOVK : OP_MOVZ) | OPCODESIZE'(hw_c);
    imm16_c  = req_q.imm[{hw_c, 4'b0000} +: HWSIZE];
    movres_c = mov_op(opcode_c, imm16_c, acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      req_q   <= '0;
      acc     <= '0;
      mask    <= '0;
      ops     <= '0;
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      steps   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_q <= '{rd: req_rd, imm: req_imm};
            mask  <= (SKIP_ZERO != 0) ? nz_mask(req_imm) : 4'b1111;
            ops   <= '0;
            state <= S_ZERO;
          end
        end
        S_ZERO, S_KEEP: begin
          acc  <= movres_c;
          mask <= mask & ~onehot_c;
          ops  <= ops + 3'd1;
          if (more_c) begin
            state <= S_KEEP;
          end else if (req_q.rd == XZR) begin
            // Writes to XZR are discarded, so retire without a write cycle
            state <= S_IDLE;
            done  <= 1'b1;
            steps <= ops + 3'd1;
          end else begin
            state   <= S_WRITE;
            wr_en   <= 1'b1;
            wr_reg  <= req_q.rd;
            wr_data <= movres_c;
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            wr_en <= 1'b0;
            done  <= 1'b1;
            steps <= ops;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
